// File: rtl/exe_unit_pkg.sv
// Shared types and constants for the exe_unit_seq execution unit.
package exe_unit_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_MUL = 3'b110,
    OP_ILL = 3'b111
  } oper_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the {V, C, N, Z} status nibble
  localparam int unsigned ST_Z = 0;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_C = 2;
  localparam int unsigned ST_V = 3;

  function automatic logic [3:0] pack_status(input logic v, input logic c,
                                             input logic n, input logic z);
    logic [3:0] st;
    st       = '0;
    st[ST_V] = v;
    st[ST_C] = c;
    st[ST_N] = n;
    st[ST_Z] = z;
    return st;
  endfunction

endpackage

// File: rtl/exe_unit_seq_if.sv
// Input (operation) and output (result) valid/ready channels of exe_unit_seq.
// master = operand/decode + writeback side, slave = the execution unit.
interface exe_unit_seq_if #(
  parameter int unsigned ARG_BITS = 8
);
  logic                i_valid;
  logic                o_ready;
  logic [2:0]          i_oper;
  logic [ARG_BITS-1:0] i_argA;
  logic [ARG_BITS-1:0] i_argB;
  logic                o_valid;
  logic                i_ready;
  logic [ARG_BITS-1:0] o_result;
  logic [3:0]          o_status;
  logic                o_err;

  modport master (
    output i_valid, i_oper, i_argA, i_argB, i_ready,
    input  o_ready, o_valid, o_result, o_status, o_err
  );

  modport slave (
    input  i_valid, i_oper, i_argA, i_argB, i_ready,
    output o_ready, o_valid, o_result, o_status, o_err
  );
endinterface

// File: rtl/exe_mul_seq.sv
// Shift-add unsigned multiplier, ARG_BITS cycles from start to done.
// Only built when EXE_MUL_EN is defined.
`ifdef EXE_MUL_EN
module exe_mul_seq #(
  parameter int unsigned ARG_BITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  start,
  input  logic [ARG_BITS-1:0]   a,
  input  logic [ARG_BITS-1:0]   b,
  output logic                  done,
  output logic [2*ARG_BITS-1:0] product
);
  localparam int unsigned CNT_W = $clog2(ARG_BITS);

  logic [2*ARG_BITS-1:0] acc;
  logic [2*ARG_BITS-1:0] mcand;
  logic [ARG_BITS-1:0]   mplier;
  logic [CNT_W-1:0]      cnt;

  // The start edge already folds in partial product 0, so ARG_BITS-1
  // further steps complete the product and done pulses on the last one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done   <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? {{ARG_BITS{1'b0}}, a} : '0;
      mcand  <= {{ARG_BITS{1'b0}}, a} << 1;
      mplier <= b >> 1;
      cnt    <= CNT_W'(ARG_BITS - 1);
      done   <= 1'b0;
    end else if (cnt != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      done   <= (cnt == CNT_W'(1));
    end else begin
      done   <= 1'b0;
    end
  end

  assign product = acc;
endmodule
`endif

// File: rtl/exe_unit_seq.sv
// Handshaked execution unit: single-cycle ALU ops plus optional sequential
// multiply. Build option: define EXE_MUL_EN to enable opcode 110 (MUL);
// otherwise 110 is reported as illegal.
module exe_unit_seq
  import exe_unit_pkg::*;
#(
  parameter int unsigned ARG_BITS = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  exe_unit_seq_if.slave  bus
);
  localparam int unsigned MSB     = ARG_BITS - 1;
  localparam int unsigned SH_BITS = $clog2(ARG_BITS);

  state_t              state_q, state_d;
  logic                accept;
  logic                is_mul;
  logic [ARG_BITS-1:0] a, b;

  logic [ARG_BITS:0]   sum;
  logic [ARG_BITS-1:0] diff;
  logic [ARG_BITS:0]   shl;
  logic [ARG_BITS-1:0] alu_res;
  logic                alu_c, alu_v, alu_err;
  logic [3:0]          alu_status;

  logic [ARG_BITS-1:0] result_q;
  logic [3:0]          status_q;
  logic                err_q;

  assign a = bus.i_argA;
  assign b = bus.i_argB;

  assign bus.o_ready = !i_rst && ((state_q == IDLE) || (state_q == DONE && bus.i_ready));
  assign bus.o_valid = (state_q == DONE);
  assign accept      = bus.i_valid && bus.o_ready;

`ifdef EXE_MUL_EN
  logic                  mul_done;
  logic [2*ARG_BITS-1:0] mul_product;
  logic [ARG_BITS-1:0]   mul_res;
  logic [3:0]            mul_status;

  assign is_mul = (bus.i_oper == OP_MUL);

  exe_mul_seq #(.ARG_BITS(ARG_BITS)) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_res    = mul_product[ARG_BITS-1:0];
  assign mul_status = pack_status(|mul_product[2*ARG_BITS-1:ARG_BITS], 1'b0,
                                  mul_res[MSB], mul_res == '0);
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle ALU evaluated straight off the input channel
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    diff    = a - b;
    // Bit ARG_BITS of the widened shift is the last bit pushed out of A
    shl     = {1'b0, a} << b[SH_BITS-1:0];
    case (bus.i_oper)
      OP_ADD: begin
        alu_res = sum[ARG_BITS-1:0];
        alu_c   = sum[ARG_BITS];
        alu_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (a < b);
        alu_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = shl[ARG_BITS-1:0];
        alu_c   = shl[ARG_BITS];
      end
      default: alu_err = 1'b1;
    endcase
    alu_status = alu_err ? 4'b0000
                         : pack_status(alu_v, alu_c, alu_res[MSB], alu_res == '0);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = is_mul ? CALC : DONE;
      end
      CALC: begin
`ifdef EXE_MUL_EN
        if (mul_done) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (accept)           state_d = is_mul ? CALC : DONE;
        else if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers: ALU results load on the accepting edge, products on completion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      result_q <= '0;
      status_q <= '0;
      err_q    <= 1'b0;
    end else if (accept && !is_mul) begin
      result_q <= alu_err ? '0 : alu_res;
      status_q <= alu_status;
      err_q    <= alu_err;
    end
`ifdef EXE_MUL_EN
    else if (state_q == CALC && mul_done) begin
      result_q <= mul_res;
      status_q <= mul_status;
      err_q    <= 1'b0;
    end
`endif
  end

  assign bus.o_result = result_q;
  assign bus.o_status = status_q;
  assign bus.o_err    = err_q;

endmodule
